// File: rtl/sipo_deserializer_if.sv
// Bundle of the serial-side and parallel-side signals of sipo_deserializer.
// The deserializer connects as slave; the serial source and parallel consumer connect as master.
interface sipo_deserializer_if #(
  parameter int WIDTH = 4
);
  logic             s_in;
  logic             s_valid;
  logic             s_start;
  logic [WIDTH-1:0] p_out;
  logic             p_valid;
  logic             p_ready;
  logic             busy;
  logic             desync;
  logic             overrun;
  logic             p_err;
  logic [0:0]       dbg_state;

  modport master (
    output s_in, s_valid, s_start, p_ready,
    input  p_out, p_valid, busy, desync, overrun, p_err, dbg_state
  );

  modport slave (
    input  s_in, s_valid, s_start, p_ready,
    output p_out, p_valid, busy, desync, overrun, p_err, dbg_state
  );
endinterface

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out deserializer with a one-entry valid/ready holding register.
// Define SIPO_PARITY_EN to append an even-parity bit to every frame and report it on p_err.
//
// Handshake: a serial bit is consumed on every edge with s_valid=1 (no back-pressure);
// a parallel word transfers on every edge with p_valid&&p_ready, and p_out/p_err stay
// stable while p_valid=1.
module sipo_deserializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic               clk,
  input logic               rst,
  sipo_deserializer_if.slave bus
);

`ifdef SIPO_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int CW = $clog2(FRAME);
  localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]       state, state_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic [WIDTH-1:0] sr, sr_nx;
  logic [WIDTH-1:0] base, shifted, word;
  logic [WIDTH-1:0] p_out_q;
  logic             p_valid_q, p_err_q, desync_q, overrun_q;
  logic             frame_start, frame_bit, frame_done, word_err;
  logic             load_word, drop_word, consume;

  always_comb begin
    frame_start = bus.s_valid && bus.s_start;
    frame_bit   = bus.s_valid && !bus.s_start && (state == SHIFT);
    frame_done  = frame_bit && (cnt == LAST);

    // A start bit always lands in an empty register, discarding any partial word.
    base = frame_start ? '0 : sr;
    if (MSB_FIRST) begin
      shifted = {base[WIDTH-2:0], bus.s_in};
    end else begin
      shifted = {bus.s_in, base[WIDTH-1:1]};
    end

`ifdef SIPO_PARITY_EN
    // The final bit is parity: the data word is already complete in sr.
    word     = sr;
    word_err = ^{sr, bus.s_in};
`else
    word     = shifted;
    word_err = 1'b0;
`endif

    state_nx = state;
    cnt_nx   = cnt;
    sr_nx    = sr;
    if (frame_start) begin
      state_nx = SHIFT;
      cnt_nx   = CW'(1);
      sr_nx    = shifted;
    end else if (frame_done) begin
      state_nx = IDLE;
      cnt_nx   = '0;
      sr_nx    = '0;
    end else if (frame_bit) begin
      cnt_nx = cnt + CW'(1);
      sr_nx  = shifted;
    end

    consume   = p_valid_q && bus.p_ready;
    load_word = frame_done && (!p_valid_q || bus.p_ready);
    drop_word = frame_done && p_valid_q && !bus.p_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      sr        <= '0;
      p_out_q   <= '0;
      p_valid_q <= 1'b0;
      p_err_q   <= 1'b0;
      desync_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      sr        <= sr_nx;
      desync_q  <= frame_start && (state == SHIFT);
      overrun_q <= drop_word;
      if (load_word) begin
        p_out_q   <= word;
        p_err_q   <= word_err;
        p_valid_q <= 1'b1;
      end else if (consume) begin
        p_valid_q <= 1'b0;
        p_err_q   <= 1'b0;
      end
    end
  end

  assign bus.p_out     = p_out_q;
  assign bus.p_valid   = p_valid_q;
  assign bus.p_err     = p_err_q;
  assign bus.desync    = desync_q;
  assign bus.overrun   = overrun_q;
  assign bus.busy      = (state == SHIFT);
  assign bus.dbg_state = state;

endmodule
